// File: rtl/mccpu_pkg.sv
// Shared types for the multicycle CPU memory port: FSM states, access kinds, IR reset value.
package mccpu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        LOAD  = 2'd1,
        STORE = 2'd2
    } acc_t;

    // sll $0,$0,0 -- architectural NOP
    localparam logic [31:0] IR_RESET_DEFAULT = 32'h0000_0000;

    function automatic logic misaligned(input logic [1:0] addr_lsb);
        return addr_lsb != 2'b00;
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts BUSY cycles of one memory access; expired flags the TIMEOUT-th cycle without completion.
module mem_wait_timer #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    // count_q holds completed cycles, so the current cycle number is count_q + 1
    localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

    logic [7:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && count_q != LAST) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = enable && (count_q == LAST);

endmodule

// File: rtl/mccpu_mem_port.sv
// Memory port for a multicycle CPU: serialises fetch/load/store onto a req/ack bus,
// stalls the controller, and reports bus timeouts and misaligned accesses.
module mccpu_mem_port
    import mccpu_pkg::*;
#(
    parameter int unsigned TIMEOUT  = 15,
    parameter logic [31:0] IR_RESET = IR_RESET_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        IRWrite,
    input  logic        IorD,
    input  logic        MemWrite,
    input  logic [31:0] PC,
    input  logic [31:0] ALUOut,
    input  logic [31:0] WriteData,
    output logic        Stall,
    output logic [31:0] IR,
    output logic [31:0] MDR,
    output logic        BusErr,
    output logic        AlignErr,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    state_t      state_q, state_d;
    acc_t        acc_q, acc_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] mdr_q, mdr_d;
    logic        buserr_q, buserr_d;
    logic        alignerr_q, alignerr_d;

    logic        access;
    acc_t        acc_req;
    logic [31:0] addr_req;
    logic        timer_clear, timer_enable, expired;

    assign access   = IRWrite | IorD;
    assign addr_req = IRWrite ? PC : ALUOut;

    always_comb begin
        if (IRWrite) begin
            acc_req = FETCH;
        end else if (MemWrite) begin
            acc_req = STORE;
        end else begin
            acc_req = LOAD;
        end
    end

    assign timer_enable = (state_q == BUSY);
    assign timer_clear  = !timer_enable;

    mem_wait_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_wait_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (timer_clear),
        .enable (timer_enable),
        .expired(expired)
    );

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        ir_d       = ir_q;
        mdr_d      = mdr_q;
        buserr_d   = 1'b0;
        alignerr_d = 1'b0;
        Stall      = 1'b0;
        case (state_q)
            IDLE: begin
                Stall = access;
                if (access) begin
                    if (misaligned(addr_req[1:0])) begin
                        state_d    = DONE;
                        alignerr_d = 1'b1;
                    end else begin
                        state_d = BUSY;
                        acc_d   = acc_req;
                        addr_d  = addr_req;
                        wdata_d = WriteData;
                    end
                end
            end
            BUSY: begin
                Stall = 1'b1;
                // an ack on the expiring cycle wins over the timeout
                if (mem_ack) begin
                    state_d = DONE;
                    if (acc_q == FETCH) begin
                        ir_d = mem_rdata;
                    end else if (acc_q == LOAD) begin
                        mdr_d = mem_rdata;
                    end
                end else if (expired) begin
                    state_d  = DONE;
                    buserr_d = 1'b1;
                    if (acc_q == FETCH) begin
                        ir_d = IR_RESET;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            acc_q      <= FETCH;
            addr_q     <= '0;
            wdata_q    <= '0;
            ir_q       <= IR_RESET;
            mdr_q      <= '0;
            buserr_q   <= 1'b0;
            alignerr_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            ir_q       <= ir_d;
            mdr_q      <= mdr_d;
            buserr_q   <= buserr_d;
            alignerr_q <= alignerr_d;
        end
    end

    // error flags are set only on entry to DONE, so they last exactly that cycle
    assign BusErr    = buserr_q;
    assign AlignErr  = alignerr_q;
    assign IR        = ir_q;
    assign MDR       = mdr_q;
    assign mem_req   = (state_q == BUSY);
    assign mem_we    = mem_req && (acc_q == STORE);
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_mccpu_mem_port.sv
// Self-checking bench for mccpu_mem_port: directed scenarios plus randomized accesses against a transaction-level model.
module tb_mccpu_mem_port;

    localparam int unsigned TO     = 15;
    localparam logic [31:0] IR_RST = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        IRWrite = 1'b0, IorD = 1'b0, MemWrite = 1'b0;
    logic [31:0] PC = '0, ALUOut = '0, WriteData = '0;
    logic        Stall;
    logic [31:0] IR, MDR;
    logic        BusErr, AlignErr;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    logic [31:0] model_ir  = IR_RST;
    logic [31:0] model_mdr = '0;

    always #5 clk = ~clk;

    mccpu_mem_port #(
        .TIMEOUT(TO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .IRWrite  (IRWrite),
        .IorD     (IorD),
        .MemWrite (MemWrite),
        .PC       (PC),
        .ALUOut   (ALUOut),
        .WriteData(WriteData),
        .Stall    (Stall),
        .IR       (IR),
        .MDR      (MDR),
        .BusErr   (BusErr),
        .AlignErr (AlignErr),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ack  (mem_ack),
        .mem_rdata(mem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One controller access; ack_at is the BUSY cycle carrying mem_ack (0 or >TO: never).
    task automatic run_access(input string tag, input logic irw, input logic iod, input logic mw,
                              input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] wd,
                              input int unsigned ack_at, input logic [31:0] rdata);
        logic        fetch, store, mis, ok, done_seen;
        logic [31:0] addr;
        int unsigned exp_stall, exp_busy, exp_bus, exp_align;
        int unsigned stall_n, busy_n, bus_n, align_n;

        fetch = irw;
        store = !irw && iod && mw;
        addr  = irw ? pc : alu;
        mis   = (addr % 4) != 0;
        ok    = (ack_at >= 1) && (ack_at <= TO);
        exp_bus = 0;
        exp_align = 0;
        if (mis) begin
            exp_stall = 1; exp_busy = 0; exp_align = 1;
        end else if (ok) begin
            exp_stall = 1 + ack_at; exp_busy = ack_at;
            if (fetch) model_ir = rdata;
            else if (!store) model_mdr = rdata;
        end else begin
            exp_stall = 1 + TO; exp_busy = TO; exp_bus = 1;
            if (fetch) model_ir = IR_RST;
        end

        stall_n = 0; busy_n = 0; bus_n = 0; align_n = 0; done_seen = 1'b0;
        @(negedge clk);
        IRWrite = irw; IorD = iod; MemWrite = mw; PC = pc; ALUOut = alu; WriteData = wd;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (Stall) stall_n++;
            if (BusErr) bus_n++;
            if (AlignErr) align_n++;
            if (mem_req) begin
                busy_n++;
                check({tag, "_addr"}, mem_addr, addr);
                check({tag, "_we"}, {31'b0, mem_we}, {31'b0, store});
                if (store) check({tag, "_wdata"}, mem_wdata, wd);
                mem_ack   = (busy_n == ack_at);
                mem_rdata = mem_ack ? rdata : $urandom;
            end else begin
                // stray acks outside BUSY must be ignored
                mem_ack   = 1'($urandom_range(0, 1));
                mem_rdata = $urandom;
            end
            if (!Stall) begin
                done_seen = 1'b1;
                check({tag, "_ir"}, IR, model_ir);
                check({tag, "_mdr"}, MDR, model_mdr);
                check({tag, "_buserr_done"}, {31'b0, BusErr}, exp_bus);
                check({tag, "_alignerr_done"}, {31'b0, AlignErr}, exp_align);
                IRWrite = 1'b0; IorD = 1'b0; MemWrite = 1'b0;
                break;
            end
            @(negedge clk);
        end
        check({tag, "_completed"}, {31'b0, done_seen}, 32'd1);
        check({tag, "_stall_cycles"}, stall_n, exp_stall);
        check({tag, "_busy_cycles"}, busy_n, exp_busy);
        check({tag, "_buserr_pulses"}, bus_n, exp_bus);
        check({tag, "_alignerr_pulses"}, align_n, exp_align);

        @(negedge clk);
        #1;
        mem_ack = 1'b0;
        check({tag, "_idle_ir"}, IR, model_ir);
        check({tag, "_idle_mdr"}, MDR, model_mdr);
        check({tag, "_idle_req"}, {31'b0, mem_req}, 32'd0);
        check({tag, "_idle_stall"}, {31'b0, Stall}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic        r_irw, r_iod, r_mw;
        logic [31:0] r_addr;

        #1;
        check("rst_ir", IR, IR_RST);
        check("rst_mdr", MDR, 32'd0);
        check("rst_req", {31'b0, mem_req}, 32'd0);
        check("rst_we", {31'b0, mem_we}, 32'd0);
        check("rst_buserr", {31'b0, BusErr}, 32'd0);
        check("rst_alignerr", {31'b0, AlignErr}, 32'd0);
        check("rst_stall", {31'b0, Stall}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        run_access("fetch40", 1'b1, 1'b0, 1'b0, 32'h0000_0040, 32'h0, 32'h0, 1, 32'h2008_0005);
        run_access("load100", 1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_0100, 32'h0, 5, 32'hDEAD_BEEF);
        run_access("store104", 1'b0, 1'b1, 1'b1, 32'h0, 32'h0000_0104, 32'h1234_5678, 3, 32'h5555_AAAA);
        run_access("fetch_timeout", 1'b1, 1'b0, 1'b0, 32'h0000_0044, 32'h0, 32'h0, 0, 32'h0);
        run_access("fetch_ack_last", 1'b1, 1'b0, 1'b0, 32'h0000_0048, 32'h0, 32'h0, TO, 32'h8C01_0004);
        run_access("load_timeout", 1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_0200, 32'h0, 0, 32'h0);
        run_access("store_mis102", 1'b0, 1'b1, 1'b1, 32'h0, 32'h0000_0102, 32'hFFFF_0000, 1, 32'h0);
        run_access("fetch_prio", 1'b1, 1'b1, 1'b1, 32'h0000_0050, 32'h0000_0301, 32'h0, 2, 32'h0123_4567);
        run_access("fetch_mis", 1'b1, 1'b0, 1'b0, 32'h0000_0053, 32'h0, 32'h0, 1, 32'h0);

        for (int n = 0; n < 30; n++) begin
            r_irw  = 1'($urandom_range(0, 1));
            r_iod  = r_irw ? 1'($urandom_range(0, 1)) : 1'b1;
            r_mw   = 1'($urandom_range(0, 1));
            r_addr = {$urandom_range(0, 32'h00FF_FFFF), 2'b00} |
                     (($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 3)) : 32'd0);
            run_access($sformatf("rnd%0d", n), r_irw, r_iod, r_mw,
                       r_irw ? r_addr : $urandom, r_irw ? $urandom : r_addr, $urandom,
                       $urandom_range(0, TO + 2), $urandom);
        end

        // reset in the middle of a fetch, then a late ack after release
        @(negedge clk);
        IRWrite = 1'b1; PC = 32'h0000_0080; mem_ack = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("midbusy_req", {31'b0, mem_req}, 32'd1);
        rst = 1'b0;
        #1;
        model_ir = IR_RST;
        model_mdr = '0;
        check("arst_req", {31'b0, mem_req}, 32'd0);
        check("arst_ir", IR, model_ir);
        check("arst_mdr", MDR, model_mdr);
        check("arst_stall_access", {31'b0, Stall}, 32'd1);
        IRWrite = 1'b0;
        #1;
        check("arst_stall_noaccess", {31'b0, Stall}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
        #1;
        check("late_ack_req", {31'b0, mem_req}, 32'd0);
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        check("late_ack_ir", IR, model_ir);
        check("late_ack_mdr", MDR, model_mdr);
        check("late_ack_stall", {31'b0, Stall}, 32'd0);

        run_access("post_rst_fetch", 1'b1, 1'b0, 1'b0, 32'h0000_0084, 32'h0, 32'h0, 2, 32'h2409_0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mccpu_mem_port.md
MCCPU_MEM_PORT -- requirements
Module: mccpu_mem_port

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15: BUSY cycles without mem_ack before a bus error is declared (legal range 1..255).
REQ-002 SHALL have parameter IR_RESET, default 32'h0000_0000: value of IR after reset and after a fetch error (encodes sll $0,$0,0, a NOP).
REQ-003 SHALL have these ports, one per line: name, direction, width, meaning.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- IRWrite  in  1  from controller: instruction fetch requested.
- IorD  in  1  from controller: data access requested.
- MemWrite  in  1  from controller: data access is a store.
- PC  in  32  fetch address.
- ALUOut  in  32  data address.
- WriteData  in  32  store data.
- Stall  out  1  hold controller state and suppress its register/PC writes.
- IR  out  32  instruction register.
- MDR  out  32  memory data register.
- BusErr  out  1  one-cycle pulse on access timeout.
- AlignErr  out  1  one-cycle pulse on misaligned access.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write enable.
- mem_addr  out  32  memory word address.
- mem_wdata  out  32  memory write data.
- mem_ack  in  1  memory completion, one cycle.
- mem_rdata  in  32  read data, valid when mem_ack=1.

Function
REQ-004 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-005 Access present = IRWrite | IorD; IRWrite SHALL take priority, so IRWrite=1 with IorD=1 is a fetch.
REQ-006 Address SHALL be PC for a fetch and ALUOut for a data access; a store is IorD & MemWrite & ~IRWrite.
REQ-007 Stall SHALL be combinational: 1 in IDLE when an access is present, 1 in BUSY, 0 in DONE, and 0 in IDLE with no access.
REQ-008 IDLE with an aligned access SHALL latch address, write data and access type, then go to BUSY.
REQ-009 IDLE with address[1:0]!=0 SHALL issue no memory request, go to DONE, and pulse AlignErr in DONE; a misaligned store SHALL write nothing.
REQ-010 BUSY SHALL drive mem_req=1 and mem_we=latched store flag, with mem_addr and mem_wdata from the latched values held stable until mem_ack.
REQ-011 On mem_ack in BUSY the block SHALL go to DONE; a fetch SHALL load IR from mem_rdata and a load SHALL load MDR; a store SHALL change neither.
REQ-012 BUSY SHALL count cycles from 1; when the count reaches TIMEOUT without mem_ack, the block SHALL go to DONE and pulse BusErr there; on a fetch, IR SHALL be loaded with IR_RESET; MDR SHALL be unchanged.
REQ-013 mem_ack on the exact timeout cycle SHALL count as success, with no BusErr.
REQ-014 DONE SHALL last exactly one cycle and go to IDLE without re-issuing the access still presented by the controller.
REQ-015 mem_ack in IDLE or DONE SHALL be ignored, with no register change.
REQ-016 Minimum access latency SHALL be 3 cycles (IDLE, BUSY with ack, DONE), so Stall is high for 2 cycles.
REQ-017 IR and MDR SHALL change only as stated in REQ-011 and REQ-012.
REQ-018 mem_req SHALL be 0 outside BUSY.

Reset
REQ-019 When rst=0, the block SHALL immediately enter IDLE and set IR=IR_RESET, MDR=0, count=0, BusErr=0, AlignErr=0, mem_req=0 and mem_we=0; Stall SHALL follow REQ-007.
REQ-020 Reset during BUSY SHALL drop mem_req asynchronously and abandon the access; a late mem_ack SHALL be ignored per REQ-015.

Structure
REQ-021 State encoding, the access-type enum (FETCH, LOAD, STORE) and the IR_RESET default SHALL live in shared package mccpu_pkg.
REQ-022 The timeout counter SHALL be sub-module mem_wait_timer, with inputs clear and enable and output expired.

Verification
REQ-023 Fetch, PC=0x0000_0040, ack on the first BUSY cycle with rdata 0x2008_0005 -> mem_addr=0x40, Stall high for 2 cycles, IR=0x2008_0005 in DONE.
REQ-024 Load, ALUOut=0x100, ack after 4 cycles with rdata 0xDEAD_BEEF -> MDR=0xDEAD_BEEF, IR unchanged, Stall high for 6 cycles.
REQ-025 Store, ALUOut=0x104, WriteData=0x1234_5678 -> mem_we=1 with wdata held until ack; MDR and IR unchanged.
REQ-026 Fetch with no ack, TIMEOUT=15 -> BusErr pulses once after 15 BUSY cycles, IR=0x0000_0000; ack exactly on cycle 15 -> no BusErr.
REQ-027 Store to ALUOut=0x102 -> mem_req never asserted, AlignErr pulses once, Stall high for 1 cycle.
REQ-028 rst=0 asserted mid-BUSY, then ack one cycle after release -> mem_req=0 immediately, IDLE, IR=IR_RESET, and the late ack is ignored.
